keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have a parameter SCAN_DIV, default 16, giving the number of clk cycles each column is driven during scanning (minimum 4).
REQ-002 The module SHALL have a parameter DEBOUNCE_CNT, default 64, giving the number of consecutive stable clk cycles required to accept a press or a release (minimum 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port row, input, 4 bits: keypad row sense lines, active-low (pulled high externally), row[0] = row index 0.
REQ-006 The module SHALL have port col, output, 4 bits: keypad column drive, one-cold, active-low, col[0] = column index 0.
REQ-007 The module SHALL have port value, output, 4 bits: code of the last accepted key, = row_idx*4 + col_idx.
REQ-008 The module SHALL have port trig, output, 1 bit: one-cycle pulse marking acceptance of a new key; value is valid in the same cycle and afterwards.
REQ-009 The module SHALL have port key_held, output, 1 bit: high from acceptance until the release is accepted.

Function
REQ-010 The row input SHALL pass through a two-flop synchronizer; all decisions use the synchronized value rsync (2-cycle input latency).
REQ-011 The FSM SHALL have the states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 In SCAN, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after every SCAN_DIV cycles, and wrap from index 3 to 0.
REQ-013 In SCAN, on the last cycle of a column dwell, if exactly one bit of rsync is low, the FSM SHALL latch row_idx and col_idx, freeze col, clear the debounce counter, and enter DEBOUNCE.
REQ-014 In SCAN, zero or two-or-more low rsync bits SHALL be ignored, and scanning SHALL continue (multi-key rejection).
REQ-015 In DEBOUNCE, the counter SHALL increment each cycle while rsync equals the latched one-cold pattern.
REQ-016 In DEBOUNCE, any other rsync value SHALL return the FSM to SCAN with col advanced to the next column; value and trig SHALL be unchanged.
REQ-017 When the counter reaches DEBOUNCE_CNT-1 with the pattern still matching, the FSM SHALL perform all of the following in the same cycle: load value with the key code, assert trig for exactly 1 cycle, set key_held, and enter HELD.
REQ-018 The total press latency SHALL be at most 2 + SCAN_DIV*4 + DEBOUNCE_CNT cycles from a row falling edge.
REQ-019 In HELD, col SHALL stay frozen and trig SHALL remain 0; when rsync == 1111, the FSM SHALL clear the counter and enter RELEASE.
REQ-020 Holding a key SHALL never produce a second trig (no auto-repeat).
REQ-021 In RELEASE, the counter SHALL increment each cycle while rsync == 1111, and any low bit SHALL return the FSM to HELD with the counter cleared.
REQ-022 When the counter reaches DEBOUNCE_CNT-1 in RELEASE, the FSM SHALL clear key_held, enter SCAN, and advance col to the next column.
REQ-023 value SHALL hold its last accepted code indefinitely and SHALL change only on a trig cycle.
REQ-024 The counter width SHALL be clog2(DEBOUNCE_CNT), the dwell counter width SHALL be clog2(SCAN_DIV), and neither counter SHALL wrap past its terminal count.

Reset
REQ-025 While reset_n = 0, the outputs SHALL be col = 1110, value = 0000, trig = 0 and key_held = 0.
REQ-026 While reset_n = 0, the FSM SHALL be in SCAN, both counters SHALL be 0, and the synchronizer flops SHALL be 1111.
REQ-027 Reset assertion SHALL take effect immediately, regardless of clk.
REQ-028 Reset asserted mid-DEBOUNCE or mid-HELD SHALL discard the pending key with no trig.
REQ-029 After reset_n rises, scanning SHALL resume from column 0 on the first clk edge.

Verification
REQ-030 Idle: reset, no keys for 200 cycles -> col cycles 1110,1101,1011,0111 every 16 cycles; trig never asserted.
REQ-031 Single press: row = 1011 while col = 1101, held 500 cycles -> exactly one trig; value = 0x9 (row 2, col 1); key_held = 1; col frozen at 1101.
REQ-032 Bounce: row toggles every 10 cycles for 100 cycles during DEBOUNCE, then stable -> no trig until 64 stable cycles; exactly one trig total.
REQ-033 Release and next key: release for 64+ cycles then press row 0 / col 3 -> key_held falls after 64 stable-high cycles; second trig with value = 0x3.
REQ-034 Multi-key: row = 1001 during a dwell -> no DEBOUNCE entry, no trig, scanning continues.
REQ-035 Reset mid-press: reset_n pulsed low at count 30 of DEBOUNCE -> col = 1110, value = 0, no trig; a fresh press after reset is accepted normally.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, one-shot key trigger and held flag.
// Latency: 2-cycle row synchronizer; a press is accepted within 2 + 4*SCAN_DIV + DEBOUNCE_CNT cycles.
// Backpressure: none; trig is a single-cycle pulse and value holds the last accepted code.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   row      - row sense lines, active-low, pulled high externally
//   col      - column drive, one-cold, active-low
//   value    - last accepted key code (row_idx*4 + col_idx)
//   trig     - one-cycle pulse when a new key is accepted
//   key_held - high from acceptance until the release is accepted
module keypad_scanner #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] value,
   output logic       trig,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   logic [3:0]    sync1;
   logic [3:0]    rsync;
   logic [1:0]    state;
   logic [1:0]    col_idx;
   logic [1:0]    row_idx;
   logic [DW-1:0] dwell;
   logic [CW-1:0] cnt;
   logic [3:0]    row_pat;

   function automatic logic is_one_cold(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (v)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Column drive and the expected row pattern are both derived from the latched indices.
   assign col     = ~(4'b0001 << col_idx);
   assign row_pat = ~(4'b0001 << row_idx);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 4'hF;
         rsync    <= 4'hF;
         state    <= ST_SCAN;
         col_idx  <= 2'd0;
         row_idx  <= 2'd0;
         dwell    <= '0;
         cnt      <= '0;
         value    <= 4'h0;
         trig     <= 1'b0;
         key_held <= 1'b0;
      end else begin
         sync1 <= row;
         rsync <= sync1;
         trig  <= 1'b0;
         case (state)
            ST_SCAN: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  // Only a single pressed row in this column is a candidate; anything else keeps scanning.
                  if (is_one_cold(rsync)) begin
                     row_idx <= low_index(rsync);
                     cnt     <= '0;
                     state   <= ST_DEBOUNCE;
                  end else begin
                     col_idx <= col_idx + 2'd1;
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (rsync == row_pat) begin
                  if (cnt == CNT_LAST) begin
                     value    <= {row_idx, col_idx};
                     trig     <= 1'b1;
                     key_held <= 1'b1;
                     state    <= ST_HELD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  // Bounce or glitch: drop the candidate and move on to the next column.
                  state   <= ST_SCAN;
                  col_idx <= col_idx + 2'd1;
                  dwell   <= '0;
               end
            end
            ST_HELD: begin
               if (rsync == 4'hF) begin
                  cnt   <= '0;
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (rsync == 4'hF) begin
                  if (cnt == CNT_LAST) begin
                     key_held <= 1'b0;
                     state    <= ST_SCAN;
                     col_idx  <= col_idx + 2'd1;
                     dwell    <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt   <= '0;
                  state <= ST_HELD;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

   localparam int SD = 16;
   localparam int DC = 64;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] value;
   logic       trig;
   logic       key_held;

   logic [15:0] keys = '0;   // keys[r*4+c] = pressed switch at row r, column c

   int n_checks = 0;
   int n_pass   = 0;
   int trig_cnt = 0;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .row      (row),
      .col      (col),
      .value    (value),
      .trig     (trig),
      .key_held (key_held)
   );

   // Switch matrix: a row is pulled low when a pressed switch connects it to a driven-low column.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model (timestamp based) ----------------
   int         cyc = 0;
   int         mode = 0;        // 0 scanning, 1 debouncing press, 2 held, 3 debouncing release
   int         base = 0;        // column shown when the current scan run started
   int         scan_start = 0;  // cycle at which the current scan run started
   int         kc = 0;          // column of the candidate key
   int         e = 0;           // first cycle of the current debounce window
   logic [3:0] pat = 4'hF;
   logic [3:0] m_rs1 = 4'hF;
   logic [3:0] m_rs2 = 4'hF;
   logic [3:0] e_val = 4'h0;
   logic       e_trig = 1'b0;
   logic       e_held = 1'b0;

   function automatic logic one_cold(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic int row_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (!v[i]) return i;
      return 0;
   endfunction

   task automatic model_step();
      logic [3:0] rs;
      int k;
      if (!reset_n) begin
         mode = 0; base = 0; scan_start = cyc + 1;
         m_rs1 = 4'hF; m_rs2 = 4'hF;
         e_val = 4'h0; e_trig = 1'b0; e_held = 1'b0;
      end else begin
         rs = m_rs2;
         e_trig = 1'b0;
         case (mode)
            0: begin
               k = cyc - scan_start;
               if ((k % SD) == SD - 1 && one_cold(rs)) begin
                  pat = rs; kc = (base + k / SD) % 4; mode = 1; e = cyc + 1;
               end
            end
            1: begin
               if (rs != pat) begin
                  mode = 0; base = (kc + 1) % 4; scan_start = cyc + 1;
               end else if (cyc - e == DC - 1) begin
                  e_val = 4'(row_of(pat) * 4 + kc); e_trig = 1'b1; e_held = 1'b1; mode = 2;
               end
            end
            2: if (rs == 4'hF) begin mode = 3; e = cyc + 1; end
            default: begin
               if (rs != 4'hF) mode = 2;
               else if (cyc - e == DC - 1) begin
                  e_held = 1'b0; mode = 0; base = (kc + 1) % 4; scan_start = cyc + 1;
               end
            end
         endcase
         m_rs2 = m_rs1;
         m_rs1 = row;
      end
      cyc++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Single compare process: every cycle, all outputs against the model.
   initial begin
      logic [3:0] one;
      logic [3:0] e_col;
      int idx;
      one = 4'b0001;
      forever begin
         @(negedge clk);
         idx   = (mode == 0) ? (base + (cyc - scan_start) / SD) % 4 : kc;
         e_col = ~(one << idx);
         if (trig) trig_cnt++;
         check($sformatf("cycle%0d col/value/trig/held", cyc),
               {22'd0, col, value, trig, key_held}, {22'd0, e_col, e_val, e_trig, e_held});
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      int t0;
      int n;
      logic [3:0] seen;

      wait_cyc(3);
      check("reset_col", col, 4'b1110);
      check("reset_value", value, 4'h0);
      check("reset_trig", trig, 1'b0);
      check("reset_held", key_held, 1'b0);
      reset_n = 1'b1;

      // Idle scanning
      t0 = trig_cnt;
      wait_cyc(8);  check("idle_col_a", col, 4'b1110);
      wait_cyc(16); check("idle_col_b", col, 4'b1101);
      wait_cyc(16); check("idle_col_c", col, 4'b1011);
      wait_cyc(16); check("idle_col_d", col, 4'b0111);
      wait_cyc(16); check("idle_col_wrap", col, 4'b1110);
      wait_cyc(128);
      check("idle_no_trig", trig_cnt - t0, 0);

      // Single press: row 2 / column 1
      keys[9] = 1'b1;
      n = 0;
      while (row == 4'hF && n < 100) begin wait_cyc(1); n++; end
      check("row_fall_seen", (row != 4'hF), 1'b1);
      n = 0;
      while (trig_cnt == t0 && n < 300) begin wait_cyc(1); n++; end
      check("press_latency", (n <= 2 + SD * 4 + DC), 1'b1);
      wait_cyc(400);
      check("press_one_trig", trig_cnt - t0, 1);
      check("press_value", value, 4'h9);
      check("press_held", key_held, 1'b1);
      check("press_col_frozen", col, 4'b1101);

      // Release, then row 0 / column 3
      keys = '0;
      wait_cyc(40); check("release_still_held", key_held, 1'b1);
      wait_cyc(40); check("release_done", key_held, 1'b0);
      t0 = trig_cnt;
      keys[3] = 1'b1;
      wait_cyc(300);
      check("key3_one_trig", trig_cnt - t0, 1);
      check("key3_value", value, 4'h3);
      check("key3_held", key_held, 1'b1);
      check("key3_col", col, 4'b0111);
      keys = '0;
      wait_cyc(100);
      check("key3_released", key_held, 1'b0);

      // Bounce on row 1 / column 2
      t0 = trig_cnt;
      for (int i = 0; i < 10; i++) begin
         keys[6] = (i % 2 == 0);
         wait_cyc(10);
      end
      check("bounce_no_trig", trig_cnt - t0, 0);
      keys[6] = 1'b1;
      wait_cyc(300);
      check("bounce_one_trig", trig_cnt - t0, 1);
      check("bounce_value", value, 4'h6);
      keys = '0;
      wait_cyc(100);

      // Multi-key: rows 1 and 2 on column 1
      t0 = trig_cnt;
      keys[5] = 1'b1;
      keys[9] = 1'b1;
      wait_cyc(100);
      seen = 4'h0;
      for (int i = 0; i < 70; i++) begin
         wait_cyc(1);
         seen = seen | ~col;
      end
      check("multi_scan_continues", seen, 4'hF);
      check("multi_no_trig", trig_cnt - t0, 0);
      check("multi_not_held", key_held, 1'b0);
      keys = '0;
      wait_cyc(50);

      // Reset in the middle of a press debounce
      keys[9] = 1'b1;
      n = 0;
      while (!(mode == 1 && cyc - e == 30) && n < 300) begin wait_cyc(1); n++; end
      check("reach_debounce_30", (n < 300), 1'b1);
      t0 = trig_cnt;
      #1 reset_n = 1'b0;
      #1;
      check("arst_col", col, 4'b1110);
      check("arst_value", value, 4'h0);
      check("arst_trig", trig, 1'b0);
      check("arst_held", key_held, 1'b0);
      wait_cyc(3);
      reset_n = 1'b1;
      check("arst_no_trig", trig_cnt - t0, 0);
      wait_cyc(300);
      check("after_reset_one_trig", trig_cnt - t0, 1);
      check("after_reset_value", value, 4'h9);
      check("after_reset_held", key_held, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
